// File: rtl/fog_pkg.sv
// Shared state encoding and reset configuration for the FOG modulation sequencer
// and its configuration checker.
package fog_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN_L = 3'd2,
        RUN_H = 3'd3,
        DRAIN = 3'd4
    } fog_state_t;

    localparam int RST_HALF_PERIOD = 256;
    localparam int RST_WAIT_CNT    = 50;
    localparam int RST_AVG_SEL     = 3;
    localparam int AVG_SEL_MAX     = 10;
    localparam int MIN_HALF_PERIOD = 8;

endpackage

// File: rtl/fog_cfg_checker.sv
// Combinational validity check for a candidate modulation config; also used by the
// host register bank to report read-back status.
module fog_cfg_checker
    import fog_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MIN_MARGIN = 4
) (
    input  logic [CNT_W-1:0] half_period,
    input  logic [CNT_W-1:0] wait_cnt,
    input  logic [CNT_W-1:0] avg_sel,
    output logic             cfg_ok
);

    localparam int SUM_W = CNT_W + 2;

    logic [SUM_W-1:0] win_sum;
    logic             avg_ok;
    logic             half_ok;

    // The acquisition window (stable wait + 2^avg_sel samples + guard) must end
    // strictly before the next edge; the sum is widened so it cannot wrap.
    always_comb begin
        avg_ok  = (avg_sel <= CNT_W'(AVG_SEL_MAX));
        half_ok = (half_period >= CNT_W'(MIN_HALF_PERIOD));
        win_sum = SUM_W'(wait_cnt) + (SUM_W'(1) << avg_sel[3:0]) + SUM_W'(MIN_MARGIN);
        cfg_ok  = avg_ok && half_ok && (win_sum < SUM_W'(half_period));
    end

endmodule

// File: rtl/fog_mod_sequencer.sv
// Square-wave modulation sequencer for the FOG error path: drives level, edge
// triggers, status and double-buffered stable-wait/averaging config.
module fog_mod_sequencer
    import fog_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MIN_MARGIN = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_cfg_load,
    input  logic [CNT_W-1:0] i_half_period,
    input  logic [CNT_W-1:0] i_wait_cnt,
    input  logic [CNT_W-1:0] i_avg_sel,
    input  logic             i_step_sync,
    output logic             o_status,
    output logic             o_mod,
    output logic             o_trig,
    output logic [CNT_W-1:0] o_wait_cnt,
    output logic [CNT_W-1:0] o_avg_sel,
    output logic             o_cfg_err,
    output logic             o_sync_lost,
    output logic [CNT_W-1:0] o_period_cnt,
    output logic [2:0]       o_state
);

    localparam int WD_W = CNT_W + 2;

    fog_state_t       state, state_nxt;
    logic [CNT_W-1:0] half_period, half_cnt;
    logic [CNT_W-1:0] pend_half, pend_wait, pend_avg;
    logic             pend_valid;
    logic [1:0]       arm_cnt;
    logic [WD_W-1:0]  wd_cnt, wd_limit;
    logic             half_tc, cfg_ok, apply_cfg, run_start, trig_nxt;

    fog_cfg_checker #(
        .CNT_W      (CNT_W),
        .MIN_MARGIN (MIN_MARGIN)
    ) u_cfg_checker (
        .half_period (i_half_period),
        .wait_cnt    (i_wait_cnt),
        .avg_sel     (i_avg_sel),
        .cfg_ok      (cfg_ok)
    );

    assign half_tc  = (half_cnt == half_period - CNT_W'(1));
    assign wd_limit = {half_period, 2'b00};
    assign o_state  = state;

    // Config is applied only at full-period boundaries: leaving IDLE and the
    // RUN_H terminal that starts a new period.
    always_comb begin
        state_nxt = state;
        trig_nxt  = 1'b0;
        apply_cfg = 1'b0;
        run_start = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable) begin
                    state_nxt = ARM;
                    apply_cfg = 1'b1;
                end
            end
            ARM: begin
                if (arm_cnt == 2'd2) begin
                    state_nxt = RUN_L;
                    trig_nxt  = 1'b1;
                    run_start = 1'b1;
                end
            end
            RUN_L: begin
                if (half_tc) begin
                    state_nxt = RUN_H;
                    trig_nxt  = 1'b1;
                end
            end
            RUN_H: begin
                if (half_tc) begin
                    if (!i_enable) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = RUN_L;
                        trig_nxt  = 1'b1;
                        apply_cfg = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (i_step_sync || half_tc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            arm_cnt  <= 2'd0;
            half_cnt <= '0;
        end else begin
            state    <= state_nxt;
            arm_cnt  <= (state == ARM) ? arm_cnt + 2'd1 : 2'd0;
            if (state_nxt != state || state == IDLE || state == ARM) half_cnt <= '0;
            else                                                     half_cnt <= half_cnt + CNT_W'(1);
        end
    end

    // Apply reads the old pending value, so a load landing on the apply cycle
    // is held back for the following boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            half_period <= CNT_W'(RST_HALF_PERIOD);
            o_wait_cnt  <= CNT_W'(RST_WAIT_CNT);
            o_avg_sel   <= CNT_W'(RST_AVG_SEL);
            pend_half   <= '0;
            pend_wait   <= '0;
            pend_avg    <= '0;
            pend_valid  <= 1'b0;
            o_cfg_err   <= 1'b0;
        end else begin
            if (apply_cfg && pend_valid) begin
                half_period <= pend_half;
                o_wait_cnt  <= pend_wait;
                o_avg_sel   <= pend_avg;
                pend_valid  <= 1'b0;
            end
            if (i_cfg_load) begin
                if (cfg_ok) begin
                    pend_half  <= i_half_period;
                    pend_wait  <= i_wait_cnt;
                    pend_avg   <= i_avg_sel;
                    pend_valid <= 1'b1;
                    o_cfg_err  <= 1'b0;
                end else begin
                    o_cfg_err  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wd_cnt       <= '0;
            o_period_cnt <= '0;
            o_sync_lost  <= 1'b0;
        end else begin
            if (state == IDLE && i_enable) o_sync_lost <= 1'b0;
            if (run_start) begin
                wd_cnt       <= '0;
                o_period_cnt <= '0;
            end else begin
                if (i_step_sync && state != IDLE) o_period_cnt <= o_period_cnt + CNT_W'(1);
                if (i_step_sync) begin
                    wd_cnt <= '0;
                end else if (state == RUN_L || state == RUN_H) begin
                    if (wd_cnt != wd_limit) wd_cnt <= wd_cnt + WD_W'(1);
                    if (wd_cnt + WD_W'(1) == wd_limit) o_sync_lost <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_trig   <= 1'b0;
            o_mod    <= 1'b0;
            o_status <= 1'b0;
        end else begin
            o_trig   <= trig_nxt;
            o_mod    <= (state_nxt == RUN_H);
            o_status <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_fog_mod_sequencer.sv
// Scoreboard bench for fog_mod_sequencer: expected trigger events are queued as
// runs are started and compared as the DUT emits each o_trig.
module tb_fog_mod_sequencer;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_load;
    logic             step_sync;
    logic [CNT_W-1:0] half_in, wait_in, avg_in;
    logic             o_status, o_mod, o_trig, o_cfg_err, o_sync_lost;
    logic [CNT_W-1:0] o_wait_cnt, o_avg_sel, o_period_cnt;
    logic [2:0]       o_state;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          at;
        logic        modv;
        logic [31:0] waitv;
        logic [31:0] avgv;
    } trig_exp_t;

    trig_exp_t sb_queue[$];

    fog_mod_sequencer #(.CNT_W(CNT_W), .MIN_MARGIN(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (en),
        .i_cfg_load    (cfg_load),
        .i_half_period (half_in),
        .i_wait_cnt    (wait_in),
        .i_avg_sel     (avg_in),
        .i_step_sync   (step_sync),
        .o_status      (o_status),
        .o_mod         (o_mod),
        .o_trig        (o_trig),
        .o_wait_cnt    (o_wait_cnt),
        .o_avg_sel     (o_avg_sel),
        .o_cfg_err     (o_cfg_err),
        .o_sync_lost   (o_sync_lost),
        .o_period_cnt  (o_period_cnt),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic pushTrig(input int at, input logic m, input int w, input int a);
        trig_exp_t e;
        e.at    = at;
        e.modv  = m;
        e.waitv = 32'(w);
        e.avgv  = 32'(a);
        sb_queue.push_back(e);
    endtask

    // Every trigger the DUT emits must match the next queued expectation.
    always @(negedge clk) begin : trig_monitor
        trig_exp_t e;
        if (rst === 1'b0 && o_trig === 1'b1) begin
            if (sb_queue.size() == 0) begin
                checkOutput("unexpected_trig", 1, 0);
            end else begin
                e = sb_queue.pop_front();
                checkOutput("trig_cycle", cyc, e.at);
                checkOutput("trig_mod", o_mod, e.modv);
                checkOutput("trig_wait", o_wait_cnt, e.waitv);
                checkOutput("trig_avg", o_avg_sel, e.avgv);
            end
        end
    end

    task automatic waitUntil(input int target);
        if (cyc > target) checkOutput("bench_schedule", cyc, target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic applyStimulus(input int half, input int wcnt, input int avg);
        half_in  = 32'(half);
        wait_in  = 32'(wcnt);
        avg_in   = 32'(avg);
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic startRun(output int s);
        en = 1'b1;
        s  = cyc + 1;
        @(negedge clk);
        checkOutput("arm_status", o_status, 1);
        checkOutput("arm_state", o_state, 1);
    endtask

    task automatic pulseStepSync();
        step_sync = 1'b1;
        @(negedge clk);
        step_sync = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_status"}, o_status, 0);
        checkOutput({tag, "_mod"}, o_mod, 0);
        checkOutput({tag, "_trig"}, o_trig, 0);
        checkOutput({tag, "_wait"}, o_wait_cnt, 50);
        checkOutput({tag, "_avg"}, o_avg_sel, 3);
        checkOutput({tag, "_cfg_err"}, o_cfg_err, 0);
        checkOutput({tag, "_sync_lost"}, o_sync_lost, 0);
        checkOutput({tag, "_period"}, o_period_cnt, 0);
        checkOutput({tag, "_state"}, o_state, 0);
    endtask

    initial begin
        int s, s2, s3;
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0; step_sync = 1'b0;
        half_in = '0; wait_in = '0; avg_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("por");

        // Run 1: defaults, config reject/accept, watchdog, enable drop and drain
        startRun(s);
        pushTrig(s + 3,    0, 50, 3);
        pushTrig(s + 259,  1, 50, 3);
        pushTrig(s + 515,  0, 50, 3);
        pushTrig(s + 771,  1, 50, 3);
        pushTrig(s + 1027, 0, 90, 4);
        pushTrig(s + 1227, 1, 90, 4);
        pushTrig(s + 1427, 0, 50, 3);
        pushTrig(s + 1683, 1, 50, 3);

        waitUntil(s + 520);
        applyStimulus(100, 90, 4);
        checkOutput("bad_cfg_err", o_cfg_err, 1);
        checkOutput("bad_cfg_wait", o_wait_cnt, 50);
        applyStimulus(200, 90, 4);
        checkOutput("good_cfg_err", o_cfg_err, 0);
        checkOutput("pending_not_applied", o_wait_cnt, 50);

        waitUntil(s + 1026);
        checkOutput("wd_before", o_sync_lost, 0);
        waitUntil(s + 1027);
        checkOutput("wd_expire", o_sync_lost, 1);

        waitUntil(s + 1240);
        applyStimulus(256, 50, 3);
        checkOutput("cfg256_err", o_cfg_err, 0);
        checkOutput("cfg256_hold", o_wait_cnt, 90);

        waitUntil(s + 1450);
        en = 1'b0;
        waitUntil(s + 1938);
        checkOutput("h_full_mod", o_mod, 1);
        checkOutput("h_full_state", o_state, 3);
        waitUntil(s + 1939);
        checkOutput("drain_mod", o_mod, 0);
        checkOutput("drain_trig", o_trig, 0);
        checkOutput("drain_state", o_state, 4);
        checkOutput("drain_status", o_status, 1);
        waitUntil(s + 1949);
        pulseStepSync();
        checkOutput("idle_state", o_state, 0);
        checkOutput("idle_status", o_status, 0);
        checkOutput("drain_sync_count", o_period_cnt, 1);
        checkOutput("sync_lost_sticky", o_sync_lost, 1);

        // Run 2: regular step_sync keeps watchdog quiet; reset mid RUN_H
        waitUntil(s + 1960);
        startRun(s2);
        checkOutput("restart_sync_lost", o_sync_lost, 0);
        for (int k = 0; k < 8; k++) begin
            pushTrig(s2 + 3 + 256 * k, 1'(k % 2), 50, 3);
        end
        waitUntil(s2 + 10);
        checkOutput("period_cleared", o_period_cnt, 0);
        for (int k = 1; k <= 3; k++) begin
            waitUntil(s2 + 2 + 512 * k);
            pulseStepSync();
            checkOutput("period_inc", o_period_cnt, 32'(k));
        end
        waitUntil(s2 + 1600);
        checkOutput("wd_fed", o_sync_lost, 0);

        waitUntil(s2 + 1800);
        applyStimulus(200, 90, 4);
        checkOutput("pre_rst_cfg_err", o_cfg_err, 0);
        checkOutput("pre_rst_wait", o_wait_cnt, 50);
        waitUntil(s2 + 1810);
        checkOutput("pre_rst_state", o_state, 3);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        checkResetValues("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Run 3: pending config must have been discarded by reset
        waitUntil(s2 + 1815);
        startRun(s3);
        pushTrig(s3 + 3,   0, 50, 3);
        pushTrig(s3 + 259, 1, 50, 3);
        pushTrig(s3 + 515, 0, 50, 3);

        waitUntil(s3 + 520);
        applyStimulus(100000, 0, 11);
        checkOutput("avg11_err", o_cfg_err, 1);
        applyStimulus(1029, 0, 10);
        checkOutput("avg10_1029_err", o_cfg_err, 0);
        applyStimulus(1028, 0, 10);
        checkOutput("avg10_1028_err", o_cfg_err, 1);
        applyStimulus(8, 0, 0);
        checkOutput("half8_err", o_cfg_err, 0);
        applyStimulus(7, 0, 0);
        checkOutput("half7_err", o_cfg_err, 1);
        checkOutput("run3_wait", o_wait_cnt, 50);

        waitUntil(s3 + 540);
        checkOutput("sb_leftover", sb_queue.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fog_mod_sequencer.md
# fog_mod_sequencer

Modulation sequencer for the FOG closed-loop error path. It generates the square-wave modulation level and the per-edge trigger pulses that the error-signal generator samples against. It also drives that generator's status, stable-wait and averaging configuration. Configuration is double-buffered and applied only at full-period boundaries; windows that do not fit a half-period are rejected. The block sits between the host register bank and the error-signal generator.

## Interface
- CNT_W, 32, width of period/wait counters and config words
- MIN_MARGIN, 4, guard cycles required between acquisition end and next edge
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  run request (level)
- i_cfg_load  in  1  one-cycle pulse: capture i_half_period/i_wait_cnt/i_avg_sel into pending buffer
- i_half_period  in  CNT_W  cycles per modulation half-period
- i_wait_cnt  in  CNT_W  stable-wait cycles after each edge
- i_avg_sel  in  CNT_W  averaging exponent, valid 0..10
- i_step_sync  in  1  one-cycle pulse from error generator per completed L/H pair
- o_status  out  1  run indication to error generator
- o_mod  out  1  modulation level, 0 = L half, 1 = H half
- o_trig  out  1  one-cycle pulse on every o_mod edge and on run start
- o_wait_cnt  out  CNT_W  active stable-wait value
- o_avg_sel  out  CNT_W  active averaging exponent
- o_cfg_err  out  1  sticky: last i_cfg_load was rejected
- o_sync_lost  out  1  sticky: no i_step_sync within 2 full periods while running
- o_period_cnt  out  CNT_W  count of i_step_sync pulses since last start, wraps
- o_state  out  3  current FSM state, for debug

## Operation
- Reset values:
  - o_status=0, o_mod=0, o_trig=0
  - o_wait_cnt=50, o_avg_sel=3, active half_period=256
  - pending empty, o_cfg_err=0, o_sync_lost=0, o_period_cnt=0, o_state=IDLE
- Config check on i_cfg_load. A config is valid iff all of the following hold:
  - avg_sel ≤ 10
  - half_period ≥ 8
  - wait_cnt + (1<<avg_sel) + MIN_MARGIN < half_period
  - Compute the sum at CNT_W+2 bits; no overflow.
- Valid config: stored as pending; o_cfg_err cleared.
- Invalid config: pending unchanged; o_cfg_err set.
- A second valid load before application overwrites the pending config.
- States:
  - IDLE: o_status=0, o_mod=0. On i_enable=1, apply any pending config, then go to ARM.
  - ARM: o_status=1 for 2 cycles so the generator registers status. Then go to RUN_L, pulsing o_trig and clearing o_period_cnt and the watchdog.
  - RUN_L: o_mod=0; the half counter runs 0..half_period-1. At terminal count, go to RUN_H, set o_mod=1, pulse o_trig.
  - RUN_H: o_mod=1. At terminal count:
    - if i_enable=0, go to DRAIN with o_mod=0 and no trig;
    - else apply any pending config, then go to RUN_L with o_mod=0 and pulse o_trig.
  - DRAIN: o_status stays 1. Go to IDLE on i_step_sync, or after half_period cycles, whichever is first.
- i_step_sync: o_period_cnt increments, in any state except IDLE, and clears the watchdog.
- Watchdog: counts cycles in RUN_L/RUN_H. It reaches 4·half_period → set o_sync_lost. Sticky until next IDLE→ARM.
- i_enable drop during RUN_L: the current period completes; the exit happens at the RUN_H terminal. Periods are never truncated.
- Simultaneous events:
  - i_cfg_load coinciding with the apply point: the pending value before the load is applied; the new value waits for the next boundary.
  - i_step_sync in the same cycle as the IDLE exit from DRAIN: counted.
- Async reset mid-run: immediate return to reset values; the pending config is discarded.

## Timing
- All outputs are registered.
- i_enable rising (sampled in IDLE) → o_status=1 next cycle → first o_trig 3 cycles after i_enable is sampled.
- o_trig is coincident with the o_mod transition cycle and exactly 1 cycle wide. Trig spacing equals half_period cycles in steady state.
- An applied config appears on o_wait_cnt/o_avg_sel in the same cycle as the RUN_L-entry o_trig. It never changes mid-period.
- o_cfg_err updates 1 cycle after i_cfg_load.

## Structure
- Shared package fog_pkg:
  - state encoding IDLE/ARM/RUN_L/RUN_H/DRAIN;
  - reset config constants (256, 50, 3);
  - AVG_SEL_MAX=10.
- One sub-module, fog_cfg_checker: a combinational validity check on the candidate config. It is reused by the host register bank for read-back status.
- Half counter, watchdog and pending buffer live in the top module.

## Test plan
- Reset, then i_enable=1 with defaults → o_trig pulses at cycles 3, 259, 515 after enable sampled; o_mod toggles at each; o_wait_cnt=50, o_avg_sel=3.
- Load half=100, wait=90, avg=4 → o_cfg_err=1; active and pending unchanged. Then load half=200, wait=90, avg=4 → o_cfg_err=0, applied at next RUN_L entry only.
- Drop i_enable mid-RUN_L with half=256 → o_mod stays high for the full H half. Then DRAIN; i_step_sync 10 cycles later → IDLE and o_status=0 next cycle.
- Running with no i_step_sync → o_sync_lost=1 exactly 4·half_period cycles after RUN_L entry. Pulse i_step_sync every 512 cycles → stays 0, o_period_cnt increments each pulse.
- Assert i_rst during RUN_H → all outputs at reset values in the same cycle; the pending config is lost and defaults are used on the next start.
- avg_sel=11 with a large half → rejected; avg_sel=10, wait=0, half=1029 → accepted (1024+4 < 1029).
